wb8_interconnect: RTL and testbench

Parametrised Wishbone-8 address decoder/interconnect between one CPU master and NSLAVES byte-wide slaves. Address windows come from base/mask parameters instead of hard-coded case arms. Slave select is registered, and a bus watchdog terminates stalled or unmapped accesses with an error acknowledge. The last bus error is captured and counted in status outputs for the top level.

---
 rtl/wb8_bus_pkg.sv | 34 +++
 rtl/wb8_bus_watchdog.sv | 30 +++
 rtl/wb8_interconnect.sv | 157 +++++++++++++++
 tb/tb_wb8_interconnect.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb8_bus_pkg.sv
// Shared definitions for the Wishbone-8 bus fabric: state encoding, error
// data default and the board memory map used by the interconnect.
package wb8_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      ERRACK = 2'd2
   } bus_state_t;

   localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;
   localparam int         NSLAVES_DEFAULT  = 4;
   localparam int         TIMEOUT_DEFAULT  = 64;

   // Board memory map: slave 0 is the lowest word of the packed vectors.
   localparam logic [31:0] MAP_RAM_BASE   = 32'hFFFFF000;
   localparam logic [31:0] MAP_RAM_MASK   = 32'hFFFFF800;
   localparam logic [31:0] MAP_UART_BASE  = 32'hFFFFF800;
   localparam logic [31:0] MAP_UART_MASK  = 32'hFFFFFF00;
   localparam logic [31:0] MAP_GPIO_BASE  = 32'hFFFFFD00;
   localparam logic [31:0] MAP_GPIO_MASK  = 32'hFFFFFF00;
   localparam logic [31:0] MAP_EXT_BASE   = 32'h80000000;
   localparam logic [31:0] MAP_EXT_MASK   = 32'h80000000;

   localparam logic [127:0] DEFAULT_SLAVE_BASE =
      {MAP_EXT_BASE, MAP_GPIO_BASE, MAP_UART_BASE, MAP_RAM_BASE};
   localparam logic [127:0] DEFAULT_SLAVE_MASK =
      {MAP_EXT_MASK, MAP_GPIO_MASK, MAP_UART_MASK, MAP_RAM_MASK};

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/wb8_bus_watchdog.sv
// Bus watchdog: counts cycles while enabled and flags when TIMEOUT cycles
// have elapsed without a clear.
module wb8_bus_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   logic [TW-1:0] timer;

   // Holds at the terminal value so a stuck enable can never wrap around.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (clear) begin
         timer <= '0;
      end else if (enable && !expired) begin
         timer <= timer + TW'(1);
      end
   end

   assign expired = (timer == TW'(TIMEOUT - 1));

endmodule

// File: rtl/wb8_interconnect.sv
// Wishbone-8 interconnect: decodes one master onto NSLAVES byte slaves with a
// registered slave select, a watchdog error ack and bus-error status capture.
module wb8_interconnect
   import wb8_bus_pkg::*;
#(
   parameter int                       NSLAVES    = NSLAVES_DEFAULT,
   parameter logic [32*NSLAVES-1:0]    SLAVE_BASE = DEFAULT_SLAVE_BASE,
   parameter logic [32*NSLAVES-1:0]    SLAVE_MASK = DEFAULT_SLAVE_MASK,
   parameter int                       TIMEOUT    = TIMEOUT_DEFAULT,
   parameter logic [7:0]               ERR_DATA   = ERR_DATA_DEFAULT
) (
   input  logic                   CLK_I,
   input  logic                   RST_I,
   input  logic [31:0]            ADR_I,
   input  logic                   STB_I,
   output logic [7:0]             DAT_O,
   output logic                   ACK_O,
   output logic                   ERR_O,
   output logic [NSLAVES-1:0]     S_STB_O,
   input  logic [8*NSLAVES-1:0]   S_DAT_I,
   input  logic [NSLAVES-1:0]     S_ACK_I,
   input  logic                   I_err_clear,
   output logic                   O_err_valid,
   output logic [31:0]            O_err_adr,
   output logic                   O_err_timeout,
   output logic [7:0]             O_err_count
);

   localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

   bus_state_t         state, next_state;
   logic [SEL_W-1:0]   sel, next_sel;
   logic [SEL_W-1:0]   hit_idx;
   logic               any_match;
   logic [NSLAVES-1:0] match;
   logic [NSLAVES-1:0] sel_onehot;
   logic               sel_ack;
   logic [7:0]         sel_dat;
   logic               expired;
   logic               err_event;
   logic               err_is_timeout;

   for (genvar i = 0; i < NSLAVES; i++) begin : g_slave
      localparam logic [31:0] BASE = SLAVE_BASE[32*i +: 32];
      localparam logic [31:0] MASK = SLAVE_MASK[32*i +: 32];
      assign match[i]      = ((ADR_I & MASK) == (BASE & MASK));
      assign sel_onehot[i] = (sel == SEL_W'(i));
   end

   // Scanning downward lets the lowest-numbered matching window win.
   always_comb begin
      hit_idx   = '0;
      any_match = 1'b0;
      for (int i = NSLAVES - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit_idx   = SEL_W'(i);
            any_match = 1'b1;
         end
      end
   end

   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      for (int i = 0; i < NSLAVES; i++) begin
         if (sel_onehot[i]) begin
            sel_ack = S_ACK_I[i];
            sel_dat = S_DAT_I[8*i +: 8];
         end
      end
   end

   wb8_bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (CLK_I),
      .rst_n   (RST_I),
      .clear   (state != ACTIVE),
      .enable  (state == ACTIVE),
      .expired (expired)
   );

   always_ff @(posedge CLK_I) begin
      if (!RST_I) begin
         state <= IDLE;
         sel   <= '0;
      end else begin
         state <= next_state;
         sel   <= next_sel;
      end
   end

   // A slave ack takes priority over both master abort and watchdog expiry.
   always_comb begin
      next_state     = state;
      next_sel       = sel;
      err_event      = 1'b0;
      err_is_timeout = 1'b0;
      ACK_O          = 1'b0;
      ERR_O          = 1'b0;
      DAT_O          = '0;
      S_STB_O        = '0;
      unique case (state)
         IDLE: begin
            if (STB_I) begin
               if (any_match) begin
                  next_state = ACTIVE;
                  next_sel   = hit_idx;
               end else begin
                  next_state = ERRACK;
                  err_event  = 1'b1;
               end
            end
         end
         ACTIVE: begin
            S_STB_O = sel_onehot & {NSLAVES{STB_I}};
            ACK_O   = sel_ack;
            DAT_O   = sel_dat;
            if (sel_ack) begin
               next_state = IDLE;
            end else if (!STB_I) begin
               next_state = IDLE;
            end else if (expired) begin
               next_state     = ERRACK;
               err_event      = 1'b1;
               err_is_timeout = 1'b1;
            end
         end
         ERRACK: begin
            ACK_O      = 1'b1;
            ERR_O      = 1'b1;
            DAT_O      = ERR_DATA;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // A clear coinciding with a new error still records that error as count 1.
   always_ff @(posedge CLK_I) begin
      if (!RST_I) begin
         O_err_valid   <= 1'b0;
         O_err_adr     <= '0;
         O_err_timeout <= 1'b0;
         O_err_count   <= '0;
      end else if (err_event) begin
         O_err_valid   <= 1'b1;
         O_err_adr     <= ADR_I;
         O_err_timeout <= err_is_timeout;
         O_err_count   <= I_err_clear ? 8'd1 : sat_inc8(O_err_count);
      end else if (I_err_clear) begin
         O_err_valid   <= 1'b0;
         O_err_count   <= '0;
      end
   end

endmodule

// File: tb/tb_wb8_interconnect.sv
// Scoreboard bench for wb8_interconnect with per-slave programmable ack delay
// and an independent address-map and error-status model.
module tb_wb8_interconnect;

   localparam int NS      = 4;
   localparam int TMO     = 64;
   localparam int NEVER   = 1000;
   localparam int MAXCYC  = 200;

   logic            CLK_I = 1'b0;
   logic            RST_I = 1'b0;
   logic [31:0]     ADR_I = '0;
   logic            STB_I = 1'b0;
   logic [7:0]      DAT_O;
   logic            ACK_O;
   logic            ERR_O;
   logic [NS-1:0]   S_STB_O;
   logic [8*NS-1:0] S_DAT_I;
   logic [NS-1:0]   S_ACK_I;
   logic            I_err_clear = 1'b0;
   logic            O_err_valid;
   logic [31:0]     O_err_adr;
   logic            O_err_timeout;
   logic [7:0]      O_err_count;

   int ack_delay [NS];
   int slv_cnt   [NS];

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         cycle;
      int         stb_cycles;
      int         sel;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   logic        m_valid;
   logic [31:0] m_adr;
   logic        m_to;
   int          m_count;

   wb8_interconnect dut (
      .CLK_I         (CLK_I),
      .RST_I         (RST_I),
      .ADR_I         (ADR_I),
      .STB_I         (STB_I),
      .DAT_O         (DAT_O),
      .ACK_O         (ACK_O),
      .ERR_O         (ERR_O),
      .S_STB_O       (S_STB_O),
      .S_DAT_I       (S_DAT_I),
      .S_ACK_I       (S_ACK_I),
      .I_err_clear   (I_err_clear),
      .O_err_valid   (O_err_valid),
      .O_err_adr     (O_err_adr),
      .O_err_timeout (O_err_timeout),
      .O_err_count   (O_err_count)
   );

   always #5 CLK_I = ~CLK_I;

   assign S_DAT_I = {8'h33, 8'h22, 8'h11, 8'h5A};

   always_comb begin
      for (int i = 0; i < NS; i++) begin
         S_ACK_I[i] = S_STB_O[i] && (slv_cnt[i] == ack_delay[i]);
      end
   end

   always @(posedge CLK_I) begin
      for (int i = 0; i < NS; i++) begin
         slv_cnt[i] <= S_STB_O[i] ? slv_cnt[i] + 1 : 0;
      end
   end

   initial begin
      for (int i = 0; i < NS; i++) begin
         slv_cnt[i]   = 0;
         ack_delay[i] = 0;
      end
   end

   function automatic int modelDecode(input logic [31:0] a);
      if (a[31:11] == 21'h1FFFFE) return 0;
      if (a[31:8] == 24'hFFFFF8)  return 1;
      if (a[31:8] == 24'hFFFFFD)  return 2;
      if (a[31])                  return 3;
      return -1;
   endfunction

   function automatic logic [7:0] modelData(input int s);
      case (s)
         0: return 8'h5A;
         1: return 8'h11;
         2: return 8'h22;
         default: return 8'h33;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic checkStatus(input string tag);
      checkOutput({tag, "_valid"},   32'(O_err_valid),   32'(m_valid));
      checkOutput({tag, "_adr"},     O_err_adr,          m_adr);
      checkOutput({tag, "_timeout"}, 32'(O_err_timeout), 32'(m_to));
      checkOutput({tag, "_count"},   32'(O_err_count),   32'(m_count));
   endtask

   // Called at posedge+1 of an idle cycle; returns at posedge+1 of the idle
   // cycle following the ack so reads can be issued back to back.
   task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                input logic clr);
      exp_t e;
      exp_t got;
      int   s;
      int   cyc;
      int   stb_seen;
      bit   done;

      s     = modelDecode(addr);
      e.sel = s;
      if (s < 0) begin
         e.data = 8'hFF; e.err = 1'b1; e.cycle = 2; e.stb_cycles = 0;
      end else if (ack_delay[s] < TMO) begin
         e.data = modelData(s); e.err = 1'b0;
         e.cycle = 2 + ack_delay[s]; e.stb_cycles = ack_delay[s] + 1;
      end else begin
         e.data = 8'hFF; e.err = 1'b1; e.cycle = 2 + TMO; e.stb_cycles = TMO;
      end
      if (e.err) begin
         m_valid = 1'b1;
         m_adr   = addr;
         m_to    = (s >= 0);
         m_count = clr ? 1 : ((m_count < 255) ? m_count + 1 : 255);
      end else if (clr) begin
         m_valid = 1'b0;
         m_count = 0;
      end
      sb.push_back(e);

      ADR_I       = addr;
      STB_I       = 1'b1;
      I_err_clear = clr;
      cyc         = 1;
      stb_seen    = 0;
      done        = 1'b0;
      while (!done && cyc <= MAXCYC) begin
         #1;
         if (cyc == 2) begin
            checkOutput({tag, "_stb"}, 32'(S_STB_O),
                        (e.sel < 0) ? 32'd0 : (32'd1 << e.sel));
         end
         if (S_STB_O != '0) stb_seen++;
         if (ACK_O) begin
            got = sb.pop_front();
            checkOutput({tag, "_data"},    32'(DAT_O), 32'(got.data));
            checkOutput({tag, "_err"},     32'(ERR_O), 32'(got.err));
            checkOutput({tag, "_latency"}, cyc,        got.cycle);
            checkOutput({tag, "_stbcyc"},  stb_seen,   got.stb_cycles);
            done = 1'b1;
         end else begin
            @(posedge CLK_I);
            #1;
            I_err_clear = 1'b0;
            cyc++;
         end
      end
      if (!done) begin
         checkOutput({tag, "_ack_seen"}, 32'(ACK_O), 32'd1);
         void'(sb.pop_front());
      end
      @(posedge CLK_I);
      #1;
      STB_I       = 1'b0;
      I_err_clear = 1'b0;
   endtask

   initial begin
      m_valid = 1'b0; m_adr = '0; m_to = 1'b0; m_count = 0;

      RST_I = 1'b0;
      repeat (3) @(posedge CLK_I);
      #2;
      checkOutput("rst_stb", 32'(S_STB_O), 32'd0);
      checkOutput("rst_ack", 32'(ACK_O),   32'd0);
      checkOutput("rst_dat", 32'(DAT_O),   32'd0);
      checkStatus("rst");
      @(posedge CLK_I);
      #1;
      RST_I = 1'b1;
      @(posedge CLK_I);
      #1;

      ack_delay[0] = 0; ack_delay[1] = 3; ack_delay[2] = NEVER; ack_delay[3] = 1;
      applyStimulus("rd_s0", 32'hFFFFF004, 1'b0);
      checkStatus("st_s0");
      applyStimulus("rd_unmap", 32'h00001000, 1'b0);
      checkStatus("st_unmap");
      applyStimulus("rd_s1", 32'hFFFFF810, 1'b0);
      applyStimulus("rd_s3", 32'h90000000, 1'b0);
      applyStimulus("rd_s2_tmo", 32'hFFFFFD02, 1'b0);
      checkStatus("st_tmo");

      ack_delay[2] = TMO - 1;
      applyStimulus("rd_s2_edge", 32'hFFFFFD02, 1'b0);
      checkStatus("st_edge");

      I_err_clear = 1'b1;
      m_valid = 1'b0; m_count = 0;
      @(posedge CLK_I);
      #1;
      I_err_clear = 1'b0;
      checkStatus("st_clear");

      for (int i = 0; i < 256; i++) begin
         applyStimulus("rd_sat", 32'h00002000 + 32'(i), 1'b0);
      end
      checkStatus("st_sat");
      applyStimulus("rd_clr_err", 32'h00003000, 1'b1);
      checkStatus("st_clr_err");

      ack_delay[2] = NEVER;
      ADR_I = 32'hFFFFFD02;
      STB_I = 1'b1;
      repeat (5) @(posedge CLK_I);
      #1;
      checkOutput("pre_rst_stb", 32'(S_STB_O), 32'd4);
      RST_I = 1'b0;
      @(posedge CLK_I);
      #1;
      m_valid = 1'b0; m_adr = '0; m_to = 1'b0; m_count = 0;
      checkOutput("midrst_stb", 32'(S_STB_O), 32'd0);
      checkOutput("midrst_ack", 32'(ACK_O),   32'd0);
      checkOutput("midrst_err", 32'(ERR_O),   32'd0);
      checkStatus("midrst");
      STB_I = 1'b0;
      RST_I = 1'b1;
      @(posedge CLK_I);
      #1;
      applyStimulus("rd_after_rst", 32'hFFFFF7FF, 1'b0);
      checkStatus("st_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
